// File: rtl/rca_pkg.sv
// Shared slice width and sequencer state encoding for the nibble-serial adder.
package rca_pkg;
  localparam int RCA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rca_seq_adder_ctrl_if.sv
// Requester-side bundle: start/done handshake, operands in, result out.
interface rca_seq_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, sub, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, sub, a, b, cin,
    output ready, busy, done, sum, cout
  );
endinterface

// File: rtl/rca.sv
// Combinational ripple-carry adder slice; zero latency, no flow control.
import rca_pkg::*;

module rca #(
  parameter int W = RCA_W
) (
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic         cin,
  output logic [W-1:0] o,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign o[i]   = i0[i] ^ i1[i] ^ c[i];
    assign c[i+1] = (i0[i] & i1[i]) | (c[i] & (i0[i] ^ i1[i]));
  end

  assign cout = c[W];
endmodule

// File: rtl/rca_seq_adder_ctrl.sv
// Wide add/sub by reusing one 4-bit rca, one nibble per cycle LSB first; done NIBBLES cycles
// after accept. start is taken only while ready (IDLE/DONE) and ignored while busy.
import rca_pkg::*;

module rca_seq_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  rca_seq_adder_ctrl_if.slave  bus
);
  localparam int W  = RCA_W * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  state_t            state;
  state_t            next_state;
  logic [CW-1:0]     count;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic              carry_q;
  logic [W-1:0]      sum_q;
  logic              cout_q;
  logic              done_q;
  logic              accept;
  logic              last;
  logic [RCA_W-1:0]  rca_o;
  logic              rca_cout;

  assign accept = (state != RUN) && bus.start;
  assign last   = (count == CW'(NIBBLES - 1));

  rca #(.W(RCA_W)) u_rca (
    .i0   (a_q[RCA_W-1:0]),
    .i1   (b_q[RCA_W-1:0]),
    .cin  (carry_q),
    .o    (rca_o),
    .cout (rca_cout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (last)      next_state = DONE;
      DONE:    next_state = bus.start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Subtraction is folded into the operand load: invert b and force carry-in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == RUN) && last;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.sub ? ~bus.b : bus.b;
        carry_q <= bus.sub ? 1'b1 : bus.cin;
        count   <= '0;
      end else if (state == RUN) begin
        sum_q   <= {rca_o, sum_q[W-1:RCA_W]};
        a_q     <= {RCA_W'(0), a_q[W-1:RCA_W]};
        b_q     <= {RCA_W'(0), b_q[W-1:RCA_W]};
        carry_q <= rca_cout;
        count   <= count + CW'(1);
        if (last) cout_q <= rca_cout;
      end
    end
  end

  assign bus.ready = (state != RUN);
  assign bus.busy  = (state == RUN);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
// Directed bench for the nibble-serial adder sequencer (NIBBLES=4, W=16).
module tb_rca_seq_adder_ctrl;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  rca_seq_adder_ctrl_if #(.NIBBLES(4)) bus();

  rca_seq_adder_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge with ready=1; returns at the negedge where done is seen.
  task automatic do_op(input logic s, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, output int lat);
    bus.start = 1'b1; bus.sub = s; bus.a = av; bus.b = bv; bus.cin = ci;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h want=0000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", bus.cout); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got=%0d want=4", lat); end
    checks++; if (bus.sum !== 16'h0100) begin errors++; $display("FAIL add_sum got=%h want=0100", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL add_cout got=%b want=0", bus.cout); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b want=0", bus.done); end
    checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_flags ready=%b busy=%b want 1/0", bus.ready, bus.busy); end
    checks++; if (bus.sum !== 16'h0100) begin errors++; $display("FAIL sum_hold got=%h want=0100", bus.sum); end

    do_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, lat);
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL ripple_sum got=%h want=0000", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("FAIL ripple_cout got=%b want=1", bus.cout); end
    @(negedge clk);
  endtask

  task automatic test_sub();
    int lat;
    do_op(1'b1, 16'h0005, 16'h0007, 1'b0, lat);
    checks++; if (bus.sum !== 16'hFFFE) begin errors++; $display("FAIL sub_borrow_sum got=%h want=fffe", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout got=%b want=0", bus.cout); end
    @(negedge clk);
    // cin=1 must be ignored for subtraction
    do_op(1'b1, 16'h1234, 16'h0234, 1'b1, lat);
    checks++; if (bus.sum !== 16'h1000) begin errors++; $display("FAIL sub_sum got=%h want=1000", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("FAIL sub_cout got=%b want=1", bus.cout); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int lat;
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL run_flags busy=%b ready=%b want 1/0", bus.busy, bus.ready); end
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h0000; bus.sub = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.sub = 1'b0;
    lat = 2;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ignore_latency got=%0d want=4", lat); end
    checks++; if (bus.sum !== 16'h3333) begin errors++; $display("FAIL ignore_sum got=%h want=3333", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL ignore_cout got=%b want=0", bus.cout); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_flags ready=%b busy=%b want 1/0", bus.ready, bus.busy); end
    checks++; if (bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_outputs sum=%h cout=%b done=%b want 0000/0/0", bus.sum, bus.cout, bus.done); end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d pulses want=0", seen); end
    do_op(1'b0, 16'h0001, 16'h0002, 1'b0, lat);
    checks++; if (lat !== 4 || bus.sum !== 16'h0003) begin errors++; $display("FAIL after_abort lat=%0d sum=%h want 4/0003", lat, bus.sum); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [3];
    logic [15:0] pb [3];
    logic        ps [3];
    logic        pc [3];
    logic [15:0] es [3];
    logic        ec [3];
    int idx, ndone, cyc, last_cyc;
    logic acc;
    pa[0] = 16'h1234; pb[0] = 16'h4321; ps[0] = 1'b0; pc[0] = 1'b0; es[0] = 16'h5555; ec[0] = 1'b0;
    pa[1] = 16'h0010; pb[1] = 16'h0001; ps[1] = 1'b1; pc[1] = 1'b0; es[1] = 16'h000F; ec[1] = 1'b1;
    pa[2] = 16'h8000; pb[2] = 16'h8001; ps[2] = 1'b0; pc[2] = 1'b1; es[2] = 16'h0002; ec[2] = 1'b1;
    idx = 0; ndone = 0; cyc = 0; last_cyc = 0;
    bus.a = pa[0]; bus.b = pb[0]; bus.sub = ps[0]; bus.cin = pc[0]; bus.start = 1'b1;
    while (ndone < 3 && cyc < 40) begin
      acc = bus.ready && bus.start;
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          bus.a = pa[idx]; bus.b = pb[idx]; bus.sub = ps[idx]; bus.cin = pc[idx];
        end else begin
          bus.start = 1'b0;
        end
      end
      if (bus.done === 1'b1) begin
        checks++; if (bus.sum !== es[ndone]) begin errors++; $display("FAIL b2b_sum%0d got=%h want=%h", ndone, bus.sum, es[ndone]); end
        checks++; if (bus.cout !== ec[ndone]) begin errors++; $display("FAIL b2b_cout%0d got=%b want=%b", ndone, bus.cout, ec[ndone]); end
        if (ndone > 0) begin
          checks++; if (cyc - last_cyc !== 5) begin errors++; $display("FAIL b2b_spacing%0d got=%0d want=5", ndone, cyc - last_cyc); end
        end
        last_cyc = cyc;
        ndone++;
      end
    end
    bus.start = 1'b0;
    checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", ndone); end
    @(negedge clk);
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_ignore_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
